// File: rtl/seq_pattern_pkg.sv
// Shared constants for the serial pattern transmitter: FSM state codes and the
// power-on pattern.
package seq_pattern_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out register; the MSB flop drives the serial line directly,
// so loading zero is how the line is parked low between bits.
module piso_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_din,
    input  logic         i_shift_en,
    output logic         o_msb
);

    logic [W-1:0] r_shift;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_din;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_shift[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends pat_reg MSB first, rep_in+1 times with GAP idle
// cycles between repeats. Define PATTERN_PARITY_EN to append an even-parity bit.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               GAP     = 2,
    parameter int               REP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             start,
    input  logic [REP_W-1:0] rep_in,
    input  logic             abort,
    output logic             xout,
    output logic             xvalid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit               HAS_GAP  = (GAP != 0);

    logic [2:0]       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [IDX_W-1:0] r_bit_idx;
    logic [REP_W-1:0] r_rep_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_xvalid;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic [IDX_W-1:0] w_bit_idx_nxt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
    logic [3:0]       w_gap_cnt_nxt;
    logic             w_piso_load;
    logic [PAT_W-1:0] w_piso_din;
    logic             w_piso_shift;
    logic             w_pat_end;
    logic             w_msb;

    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_rep_cnt_nxt = r_rep_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_piso_load   = 1'b0;
        w_piso_din    = '0;
        w_piso_shift  = 1'b0;
        w_pat_end     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_idx_nxt = IDX_MSB;
                    w_rep_cnt_nxt = rep_in;
                    w_piso_load   = 1'b1;
                    w_piso_din    = load ? pat_in : r_pat;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_piso_load = 1'b1;
                end else if (r_bit_idx == '0) begin
`ifdef PATTERN_PARITY_EN
                    w_state_nxt = ST_PARITY;
                    w_piso_load = 1'b1;
                    w_piso_din  = {^r_pat, {(PAT_W-1){1'b0}}};
`else
                    w_pat_end   = 1'b1;
`endif
                end else begin
                    w_bit_idx_nxt = r_bit_idx - 1'b1;
                    w_piso_shift  = 1'b1;
                end
            end
`ifdef PATTERN_PARITY_EN
            ST_PARITY: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_piso_load = 1'b1;
                end else begin
                    w_pat_end = 1'b1;
                end
            end
`endif
            ST_GAP: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_idx_nxt = IDX_MSB;
                    w_rep_cnt_nxt = r_rep_cnt - 1'b1;
                    w_piso_load   = 1'b1;
                    w_piso_din    = r_pat;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_piso_load = 1'b1;
            end
        endcase

        // End of one pattern copy: finish, idle for the gap, or restart immediately.
        if (w_pat_end) begin
            w_piso_load = 1'b1;
            if (r_rep_cnt == '0) begin
                w_state_nxt = ST_DONE;
            end else if (HAS_GAP) begin
                w_state_nxt   = ST_GAP;
                w_gap_cnt_nxt = GAP_LAST;
            end else begin
                w_state_nxt   = ST_SHIFT;
                w_bit_idx_nxt = IDX_MSB;
                w_rep_cnt_nxt = r_rep_cnt - 1'b1;
                w_piso_din    = r_pat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pat     <= PATTERN;
            r_bit_idx <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            r_xvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if ((r_state == ST_IDLE) && load) begin
                r_pat <= pat_in;
            end
            // Status flags decode the next state so they line up with the serial bit.
            r_xvalid <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_PARITY);
            r_busy   <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_GAP) ||
                        (w_state_nxt == ST_PARITY);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    piso_shift #(
        .W (PAT_W)
    ) u_piso (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_piso_load),
        .i_din      (w_piso_din),
        .i_shift_en (w_piso_shift),
        .o_msb      (w_msb)
    );

    assign xout   = w_msb;
    assign xvalid = r_xvalid;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed and random bursts compared
// cycle-by-cycle against a queue of expected outputs built from the pattern rules.
module tb_seq_pattern_tx;
    import seq_pattern_pkg::*;

    localparam int PAT_W = 4;
    localparam int GAP   = 2;
    localparam int REP_W = 4;
`ifdef PATTERN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic xout;
        logic xvalid;
        logic busy;
        logic done;
    } obs_t;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             load   = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             start  = 1'b0;
    logic [REP_W-1:0] rep_in = '0;
    logic             abort  = 1'b0;
    logic             xout;
    logic             xvalid;
    logic             busy;
    logic             done;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [PAT_W-1:0] m_pat;
    obs_t             exp_q[$];

    seq_pattern_tx #(
        .PAT_W (PAT_W),
        .GAP   (GAP),
        .REP_W (REP_W)
    ) dut (
        .clk    (clk),
        .rst    (rst_n),
        .load   (load),
        .pat_in (pat_in),
        .start  (start),
        .rep_in (rep_in),
        .abort  (abort),
        .xout   (xout),
        .xvalid (xvalid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {xout, xvalid, busy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Busy cycles of one burst, straight from the transmission length formula.
    function automatic int burst_len(input int rep);
        return (rep + 1) * (PAT_W + PAR) + rep * GAP;
    endfunction

    task automatic build(input logic [PAT_W-1:0] pat, input int rep);
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
            if (PAR != 0) exp_q.push_back({^pat, 1'b1, 1'b1, 1'b0});
            if (r < rep) for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
    endtask

    // One burst: optional load with the start, optional abort at entry abort_at,
    // optional load+start (pat_in=0) injected while busy or in DONE at inject_at.
    task automatic burst(input string name, input logic do_load, input logic [PAT_W-1:0] new_pat,
                         input int rep, input int abort_at, input int inject_at, input logic abort_w_start);
        if (do_load) m_pat = new_pat;
        build(m_pat, rep);
        if (abort_at >= 0) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            repeat (3) exp_q.push_back(4'b0000);
        end
        load   = do_load;
        pat_in = new_pat;
        rep_in = 4'(rep);
        start  = 1'b1;
        abort  = abort_w_start;
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(sample()), 32'(exp_q[i]));
            load  = 1'b0;
            start = 1'b0;
            abort = (i == abort_at);
            if (i == inject_at) begin
                load   = 1'b1;
                pat_in = '0;
                start  = 1'b1;
            end
            tick();
        end
        load  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        m_pat = DEFAULT_PATTERN;
        #2 rst_n = 1'b0;
        #1 check("reset_async", 32'(sample()), 32'h0);
        repeat (2) @(posedge clk);
        #1 check("reset_held", 32'(sample()), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("reset_release", 32'(sample()), 32'h0);

        burst("default", 1'b0, '0, 0, -1, -1, 1'b0);
        burst("load_start", 1'b1, 4'b1101, 2, -1, -1, 1'b0);
        burst("ignore_mid", 1'b0, '0, 1, -1, 3, 1'b0);
        burst("ignore_done", 1'b0, '0, 1, -1, burst_len(1), 1'b0);
        burst("after_ignore", 1'b0, '0, 0, -1, -1, 1'b0);
        burst("abort_rep2", 1'b0, '0, 2, (PAT_W + PAR + GAP) + 2, -1, 1'b0);
        burst("fresh", 1'b0, '0, 0, -1, -1, 1'b0);
        burst("start_abort", 1'b0, '0, 0, -1, -1, 1'b1);
        burst("rep_max", 1'b1, 4'b1001, (1 << REP_W) - 1, -1, -1, 1'b0);

        // Asynchronous reset in the first gap cycle, away from any clock edge.
        build(m_pat, 1);
        rep_in = 4'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= PAT_W + PAR; i++) begin
            check($sformatf("pre_rst[%0d]", i), 32'(sample()), 32'(exp_q[i]));
            if (i < PAT_W + PAR) tick();
        end
        #2 rst_n = 1'b0;
        m_pat = DEFAULT_PATTERN;
        #1 check("rst_mid_gap", 32'(sample()), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rst_mid_gap_idle", 32'(sample()), 32'h0);
        burst("post_rst", 1'b0, '0, 0, -1, -1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            logic [PAT_W-1:0] rp;
            int               rr;
            int               ra;
            rp = PAT_W'($urandom);
            rr = $urandom_range(0, 3);
            ra = ($urandom_range(0, 2) == 0) ? $urandom_range(0, burst_len(rr) - 1) : -1;
            burst($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), rp, rr, ra, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
